// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: bus widths and the bus-owner state encoding.
package mem_bus_arbiter_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_VID  = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/mem_bus_arbiter_sat_counter.sv
// Saturating up-counter with a variable increment and a synchronous clear.
// Clear wins over increment.
module mem_bus_arbiter_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15,
    parameter int INC_W = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic [INC_W-1:0] i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH:0] MAX_V = (WIDTH+1)'(MAX);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_sum;

    // One extra bit of headroom so the saturation test cannot wrap.
    assign w_sum = {1'b0, r_count} + (WIDTH+1)'(i_inc);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (w_sum >= MAX_V) begin
            r_count <= MAX_V[WIDTH-1:0];
        end else begin
            r_count <= w_sum[WIDTH-1:0];
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter: video has priority with a bounded burst, CPU wait is bounded.
// Optional stall statistics output is enabled with `define MEM_ARB_STATS_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int VID_BURST_MAX = 8,
    parameter int CPU_MAX_WAIT  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    output logic                  o_cpu_gnt,
    output logic                  o_cpu_rvalid,
    input  logic                  i_vid_req,
    input  logic [ADDR_WIDTH-1:0] i_vid_addr,
    output logic                  o_vid_gnt,
    output logic                  o_vid_rvalid,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_re,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]           o_stall_cycles
`endif
);

    localparam int BW = $clog2(VID_BURST_MAX + 1);
    localparam int WW = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [BW-1:0] BURST_MAX_V = BW'(VID_BURST_MAX);
    localparam logic [WW-1:0] WAIT_MAX_V  = WW'(CPU_MAX_WAIT);

    arb_owner_t            r_state;
    logic                  r_rd_valid;
    logic [BW-1:0]         w_burst_cnt;
    logic [WW-1:0]         w_wait_cnt;
    logic                  w_cpu_gnt;
    logic                  w_vid_gnt;
    logic                  w_cpu_wait;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_mem_re;
    logic                  w_mem_we;

    // Starvation guard first, then video unless its burst is exhausted while the CPU waits.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_vid_gnt = 1'b0;
        if (!i_reset) begin
            if (i_cpu_req && (w_wait_cnt == WAIT_MAX_V)) begin
                w_cpu_gnt = 1'b1;
            end else if (i_vid_req && !(i_cpu_req && (w_burst_cnt == BURST_MAX_V))) begin
                w_vid_gnt = 1'b1;
            end else if (i_cpu_req) begin
                w_cpu_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_re    = 1'b0;
        w_mem_we    = 1'b0;
        if (w_cpu_gnt) begin
            w_mem_addr  = i_cpu_addr;
            w_mem_wdata = i_cpu_wdata;
            w_mem_re    = !i_cpu_we;
            w_mem_we    = i_cpu_we;
        end else if (w_vid_gnt) begin
            w_mem_addr = i_vid_addr;
            w_mem_re   = 1'b1;
        end
    end

    // r_state records the owner of the last issued cycle; with r_rd_valid it steers rvalid.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_mem_re;
            if (w_cpu_gnt) begin
                r_state <= S_CPU;
            end else if (w_vid_gnt) begin
                r_state <= S_VID;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

    assign w_cpu_wait = i_cpu_req && !w_cpu_gnt;

    mem_bus_arbiter_sat_counter #(
        .WIDTH (BW),
        .MAX   (VID_BURST_MAX),
        .INC_W (1)
    ) u_burst_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (!w_vid_gnt),
        .i_inc   (w_vid_gnt),
        .o_count (w_burst_cnt)
    );

    mem_bus_arbiter_sat_counter #(
        .WIDTH (WW),
        .MAX   (CPU_MAX_WAIT),
        .INC_W (1)
    ) u_wait_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_cpu_gnt || !i_cpu_req),
        .i_inc   (w_cpu_wait),
        .o_count (w_wait_cnt)
    );

`ifdef MEM_ARB_STATS_EN
    logic [1:0] w_stall_inc;

    assign w_stall_inc = {1'b0, w_cpu_wait} + {1'b0, (i_vid_req && !w_vid_gnt)};

    mem_bus_arbiter_sat_counter #(
        .WIDTH (16),
        .MAX   (65535),
        .INC_W (2)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (1'b0),
        .i_inc   (w_stall_inc),
        .o_count (o_stall_cycles)
    );
`endif

    assign o_cpu_gnt    = w_cpu_gnt;
    assign o_vid_gnt    = w_vid_gnt;
    assign o_mem_addr   = w_mem_addr;
    assign o_mem_wdata  = w_mem_wdata;
    assign o_mem_re     = w_mem_re;
    assign o_mem_we     = w_mem_we;
    assign o_rdata      = i_mem_rdata;
    // Gated by reset so a read in flight when reset arrives never reports data.
    assign o_cpu_rvalid = r_rd_valid && (r_state == S_CPU) && !i_reset;
    assign o_vid_rvalid = r_rd_valid && (r_state == S_VID) && !i_reset;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter: a default-parameter instance with a memory model,
// plus a short-burst instance sharing the same stimulus.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic                  clock;
    logic                  reset;
    logic                  cpuReq;
    logic                  cpuWe;
    logic [ADDR_WIDTH-1:0] cpuAddr;
    logic [DATA_WIDTH-1:0] cpuWdata;
    logic                  vidReq;
    logic [ADDR_WIDTH-1:0] vidAddr;

    logic                  cpuGnt, cpuRvalid, vidGnt, vidRvalid, memRe, memWe;
    logic [DATA_WIDTH-1:0] rdata, memWdata, memRdata;
    logic [ADDR_WIDTH-1:0] memAddr;

    logic                  altCpuGnt, altCpuRvalid, altVidGnt, altVidRvalid, altMemRe, altMemWe;
    logic [DATA_WIDTH-1:0] altRdata, altMemWdata;
    logic [ADDR_WIDTH-1:0] altMemAddr;
    logic [DATA_WIDTH-1:0] altMemRdata;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]           stallCycles, altStallCycles;
`endif

    logic [DATA_WIDTH-1:0] mem [0:65535];

    int nChecks = 0;
    int nFails  = 0;

    mem_bus_arbiter dut (
        .i_clk        (clock),
        .i_reset      (reset),
        .i_cpu_req    (cpuReq),
        .i_cpu_we     (cpuWe),
        .i_cpu_addr   (cpuAddr),
        .i_cpu_wdata  (cpuWdata),
        .o_cpu_gnt    (cpuGnt),
        .o_cpu_rvalid (cpuRvalid),
        .i_vid_req    (vidReq),
        .i_vid_addr   (vidAddr),
        .o_vid_gnt    (vidGnt),
        .o_vid_rvalid (vidRvalid),
        .o_rdata      (rdata),
        .o_mem_addr   (memAddr),
        .o_mem_re     (memRe),
        .o_mem_we     (memWe),
        .o_mem_wdata  (memWdata),
        .i_mem_rdata  (memRdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .o_stall_cycles (stallCycles)
`endif
    );

    mem_bus_arbiter #(
        .VID_BURST_MAX (2),
        .CPU_MAX_WAIT  (15)
    ) dutAlt (
        .i_clk        (clock),
        .i_reset      (reset),
        .i_cpu_req    (cpuReq),
        .i_cpu_we     (cpuWe),
        .i_cpu_addr   (cpuAddr),
        .i_cpu_wdata  (cpuWdata),
        .o_cpu_gnt    (altCpuGnt),
        .o_cpu_rvalid (altCpuRvalid),
        .i_vid_req    (vidReq),
        .i_vid_addr   (vidAddr),
        .o_vid_gnt    (altVidGnt),
        .o_vid_rvalid (altVidRvalid),
        .o_rdata      (altRdata),
        .o_mem_addr   (altMemAddr),
        .o_mem_re     (altMemRe),
        .o_mem_we     (altMemWe),
        .o_mem_wdata  (altMemWdata),
        .i_mem_rdata  (altMemRdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .o_stall_cycles (altStallCycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign altMemRdata = '0;

    // Synchronous memory model: read data appears the cycle after the read strobe.
    always @(posedge clock) begin
        if (memWe) mem[memAddr] <= memWdata;
        if (memRe) memRdata <= mem[memAddr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic cReq, input logic cWe, input logic [ADDR_WIDTH-1:0] cAddr,
                                 input logic [DATA_WIDTH-1:0] cWdata, input logic vReq,
                                 input logic [ADDR_WIDTH-1:0] vAddr);
        cpuReq   = cReq;
        cpuWe    = cWe;
        cpuAddr  = cAddr;
        cpuWdata = cWdata;
        vidReq   = vReq;
        vidAddr  = vAddr;
        #1;
    endtask

    // Drop-and-retry sequence: CPU request pattern and the cycle its grant is due.
    logic [7:0] dropCpuReq = 8'b1111_1011;
    logic [7:0] dropCpuGnt = 8'b1000_0000;

    initial begin
        mem[16'h0123] <= 8'hA7;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0123, 8'h00, 1'b1, 16'hD000);
        tick();
        tick();
        checkOutput("rst_cpu_gnt", {31'd0, cpuGnt}, 32'd0);
        checkOutput("rst_vid_gnt", {31'd0, vidGnt}, 32'd0);
        checkOutput("rst_cpu_rvalid", {31'd0, cpuRvalid}, 32'd0);
        checkOutput("rst_vid_rvalid", {31'd0, vidRvalid}, 32'd0);
        checkOutput("rst_mem_re", {31'd0, memRe}, 32'd0);

        $display("[TB] CPU-only read");
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'h0123, 8'h00, 1'b0, 16'h0000);
        checkOutput("rd_cpu_gnt", {31'd0, cpuGnt}, 32'd1);
        checkOutput("rd_vid_gnt", {31'd0, vidGnt}, 32'd0);
        checkOutput("rd_mem_re", {31'd0, memRe}, 32'd1);
        checkOutput("rd_mem_we", {31'd0, memWe}, 32'd0);
        checkOutput("rd_mem_addr", {16'd0, memAddr}, 32'h0123);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000);
        checkOutput("rd_cpu_rvalid", {31'd0, cpuRvalid}, 32'd1);
        checkOutput("rd_vid_rvalid", {31'd0, vidRvalid}, 32'd0);
        checkOutput("rd_rdata", {24'd0, rdata}, 32'hA7);
        checkOutput("idle_mem_re", {31'd0, memRe}, 32'd0);
        checkOutput("idle_mem_addr", {16'd0, memAddr}, 32'd0);

        $display("[TB] CPU write then video read-back");
        tick();
        applyStimulus(1'b1, 1'b1, 16'hD005, 8'h5A, 1'b0, 16'h0000);
        checkOutput("wr_cpu_gnt", {31'd0, cpuGnt}, 32'd1);
        checkOutput("wr_mem_we", {31'd0, memWe}, 32'd1);
        checkOutput("wr_mem_re", {31'd0, memRe}, 32'd0);
        checkOutput("wr_mem_wdata", {24'd0, memWdata}, 32'h5A);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'hD005);
        checkOutput("wr_no_rvalid", {31'd0, cpuRvalid}, 32'd0);
        checkOutput("vrd_vid_gnt", {31'd0, vidGnt}, 32'd1);
        checkOutput("vrd_mem_addr", {16'd0, memAddr}, 32'hD005);
        checkOutput("vrd_mem_we", {31'd0, memWe}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000);
        checkOutput("vrd_vid_rvalid", {31'd0, vidRvalid}, 32'd1);
        checkOutput("vrd_cpu_rvalid", {31'd0, cpuRvalid}, 32'd0);
        checkOutput("vrd_rdata", {24'd0, rdata}, 32'h5A);

        $display("[TB] Reset during a pending CPU read");
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0123, 8'h00, 1'b0, 16'h0000);
        checkOutput("mr_cpu_gnt", {31'd0, cpuGnt}, 32'd1);
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0123, 8'h00, 1'b1, 16'hD000);
        checkOutput("mr_cpu_rvalid", {31'd0, cpuRvalid}, 32'd0);
        checkOutput("mr_cpu_gnt_rst", {31'd0, cpuGnt}, 32'd0);
        checkOutput("mr_vid_gnt_rst", {31'd0, vidGnt}, 32'd0);
        tick();
        checkOutput("mr_cpu_rvalid2", {31'd0, cpuRvalid}, 32'd0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'h0040, 8'h00, 1'b0, 16'h0000);
        checkOutput("mr_post_cpu_gnt", {31'd0, cpuGnt}, 32'd1);
        checkOutput("mr_post_mem_addr", {16'd0, memAddr}, 32'h0040);

        $display("[TB] Both masters held from reset");
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0100, 8'h00, 1'b1, 16'hD100);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput($sformatf("both_cpu_gnt[%0d]", i), {31'd0, cpuGnt}, (i % 5 == 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("both_vid_gnt[%0d]", i), {31'd0, vidGnt}, (i % 5 == 4) ? 32'd0 : 32'd1);
            checkOutput($sformatf("alt_cpu_gnt[%0d]", i), {31'd0, altCpuGnt}, (i % 3 == 2) ? 32'd1 : 32'd0);
            checkOutput($sformatf("alt_vid_gnt[%0d]", i), {31'd0, altVidGnt}, (i % 3 == 2) ? 32'd0 : 32'd1);
            checkOutput($sformatf("alt_mem_re[%0d]", i), {31'd0, altMemRe}, 32'd1);
            tick();
        end
`ifdef MEM_ARB_STATS_EN
        checkOutput("stall_cycles", {16'd0, stallCycles}, 32'd10);
        checkOutput("alt_stall_cycles", {16'd0, altStallCycles}, 32'd10);
`endif

        $display("[TB] CPU drops its request before being granted");
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0200, 8'h00, 1'b1, 16'hD200);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cpuReq = dropCpuReq[i];
            #1;
            checkOutput($sformatf("drop_cpu_gnt[%0d]", i), {31'd0, cpuGnt}, {31'd0, dropCpuGnt[i]});
            checkOutput($sformatf("drop_vid_gnt[%0d]", i), {31'd0, vidGnt}, {31'd0, !dropCpuGnt[i]});
            tick();
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
